// File: rtl/debug_hart_ctrl_pkg.sv
// Shared types for the hart-side debug run-control sequencer.
package debug_hart_ctrl_pkg;

  typedef enum logic [2:0] {
    S_RESET    = 3'd0,
    S_RUN      = 3'd1,
    S_HALTING  = 3'd2,
    S_HALTED   = 3'd3,
    S_RESUMING = 3'd4,
    S_STEP     = 3'd5
  } dbg_state_e;

  localparam logic [2:0] CAUSE_EBREAK  = 3'd1;
  localparam logic [2:0] CAUSE_HALTREQ = 3'd3;
  localparam logic [2:0] CAUSE_STEP    = 3'd4;

endpackage

// File: rtl/debug_hart_ctrl_if.sv
// DM/core-facing signal bundle of the run-control sequencer.
interface debug_hart_ctrl_if;
  logic       I_HALTREQ;
  logic       I_RESUMEREQ;
  logic       I_HARTRESET;
  logic       I_NDMRESET;
  logic       I_STEP;
  logic       I_CORE_IDLE;
  logic       I_CORE_EBREAK;
  logic       I_CORE_RETIRE;
  logic       O_HALTED;
  logic       O_RUNNING;
  logic       O_RESUMEACK;
  logic       O_CORE_STALL;
  logic       O_DBG_MODE;
  logic       O_DPC_WE;
  logic [2:0] O_CAUSE;
  logic       O_CORE_RESUME;
  logic       O_CORE_RST_N;
  logic       O_SYS_RST_N;

  modport master (
    output I_HALTREQ, I_RESUMEREQ, I_HARTRESET, I_NDMRESET, I_STEP,
           I_CORE_IDLE, I_CORE_EBREAK, I_CORE_RETIRE,
    input  O_HALTED, O_RUNNING, O_RESUMEACK, O_CORE_STALL, O_DBG_MODE,
           O_DPC_WE, O_CAUSE, O_CORE_RESUME, O_CORE_RST_N, O_SYS_RST_N
  );

  modport slave (
    input  I_HALTREQ, I_RESUMEREQ, I_HARTRESET, I_NDMRESET, I_STEP,
           I_CORE_IDLE, I_CORE_EBREAK, I_CORE_RETIRE,
    output O_HALTED, O_RUNNING, O_RESUMEACK, O_CORE_STALL, O_DBG_MODE,
           O_DPC_WE, O_CAUSE, O_CORE_RESUME, O_CORE_RST_N, O_SYS_RST_N
  );
endinterface

// File: rtl/debug_hart_ctrl_rst_stretch.sv
// Reset stretcher: holds off exit until RST_CYCLES quiet cycles follow the last request.
module debug_hart_ctrl_rst_stretch #(
  parameter int unsigned RST_CYCLES = 16,
  parameter int unsigned RCW        = 5
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_i,
  input  logic active_i,
  output logic done_o
);

  logic [RCW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= RCW'(RST_CYCLES);
    end else if (req_i) begin
      cnt_q <= RCW'(RST_CYCLES);
    end else if (active_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - RCW'(1);
    end
  end

  assign done_o = active_i && !req_i && (cnt_q == '0);

endmodule

// File: rtl/debug_hart_ctrl.sv
// Hart-side run-control sequencer: maps DM halt/resume/reset requests onto core
// stall, debug-mode entry/exit, DPC capture and reset pulses.
module debug_hart_ctrl
  import debug_hart_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES = 16,
  parameter int unsigned RCW        = 5
) (
  input  logic               CLK,
  input  logic               RST_N,
  debug_hart_ctrl_if.slave   bus
);

  dbg_state_e state_q;
  logic       sys_rst_q, resume_prev_q;
  logic [2:0] cause_pend_q, cause_q;
  logic       halted_q, running_q, resumeack_q, stall_q, dbg_mode_q;
  logic       dpc_we_q, core_resume_q, core_rst_n_q, sys_rst_n_q;
  logic       rst_req, rst_done, resume_edge;

  assign rst_req     = bus.I_HARTRESET | bus.I_NDMRESET;
  assign resume_edge = bus.I_RESUMEREQ & ~resume_prev_q;

  debug_hart_ctrl_rst_stretch #(
    .RST_CYCLES (RST_CYCLES),
    .RCW        (RCW)
  ) u_rst_stretch (
    .clk_i    (CLK),
    .rst_ni   (RST_N),
    .req_i    (rst_req),
    .active_i (state_q == S_RESET),
    .done_o   (rst_done)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= S_RESET;
      sys_rst_q     <= 1'b1;
      resume_prev_q <= 1'b0;
      cause_pend_q  <= '0;
      cause_q       <= '0;
      halted_q      <= 1'b0;
      running_q     <= 1'b0;
      resumeack_q   <= 1'b0;
      stall_q       <= 1'b1;
      dbg_mode_q    <= 1'b0;
      dpc_we_q      <= 1'b0;
      core_resume_q <= 1'b0;
      core_rst_n_q  <= 1'b0;
      sys_rst_n_q   <= 1'b0;
    end else begin
      resume_prev_q <= bus.I_RESUMEREQ;
      dpc_we_q      <= 1'b0;
      core_resume_q <= 1'b0;
      if (rst_req) begin
        state_q      <= S_RESET;
        sys_rst_q    <= sys_rst_q | bus.I_NDMRESET;
        resumeack_q  <= 1'b0;
        halted_q     <= 1'b0;
        running_q    <= 1'b0;
        stall_q      <= 1'b1;
        dbg_mode_q   <= 1'b0;
        core_rst_n_q <= 1'b0;
        sys_rst_n_q  <= ~(sys_rst_q | bus.I_NDMRESET);
      end else begin
        unique case (state_q)
          S_RESET: begin
            if (rst_done) begin
              state_q      <= S_RUN;
              sys_rst_q    <= 1'b0;
              core_rst_n_q <= 1'b1;
              sys_rst_n_q  <= 1'b1;
              running_q    <= 1'b1;
              stall_q      <= 1'b0;
            end
          end
          // Step mode ignores HALTREQ; only ebreak or a retire ends the step.
          S_RUN, S_STEP: begin
            if (bus.I_CORE_EBREAK || ((state_q == S_STEP) ? bus.I_CORE_RETIRE : bus.I_HALTREQ)) begin
              state_q      <= S_HALTING;
              running_q    <= 1'b0;
              stall_q      <= 1'b1;
              cause_pend_q <= bus.I_CORE_EBREAK ? CAUSE_EBREAK :
                              (state_q == S_STEP) ? CAUSE_STEP : CAUSE_HALTREQ;
            end
          end
          S_HALTING: begin
            if (bus.I_CORE_IDLE) begin
              state_q    <= S_HALTED;
              halted_q   <= 1'b1;
              dbg_mode_q <= 1'b1;
              dpc_we_q   <= 1'b1;
              cause_q    <= cause_pend_q;
            end
          end
          S_HALTED: begin
            if (resume_edge && !bus.I_HALTREQ) begin
              state_q       <= S_RESUMING;
              halted_q      <= 1'b0;
              core_resume_q <= 1'b1;
              resumeack_q   <= 1'b0;
            end
          end
          S_RESUMING: begin
            state_q     <= bus.I_STEP ? S_STEP : S_RUN;
            resumeack_q <= 1'b1;
            dbg_mode_q  <= 1'b0;
            stall_q     <= 1'b0;
            running_q   <= 1'b1;
          end
          default: state_q <= S_RESET;
        endcase
      end
    end
  end

  assign bus.O_HALTED      = halted_q;
  assign bus.O_RUNNING     = running_q;
  assign bus.O_RESUMEACK   = resumeack_q;
  assign bus.O_CORE_STALL  = stall_q;
  assign bus.O_DBG_MODE    = dbg_mode_q;
  assign bus.O_DPC_WE      = dpc_we_q;
  assign bus.O_CAUSE       = cause_q;
  assign bus.O_CORE_RESUME = core_resume_q;
  assign bus.O_CORE_RST_N  = core_rst_n_q;
  assign bus.O_SYS_RST_N   = sys_rst_n_q;

endmodule

// File: tb/tb_debug_hart_ctrl.sv
// Bench for debug_hart_ctrl: directed run-control scenarios against a flag-level model.
module tb_debug_hart_ctrl;

  localparam int unsigned RST = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  debug_hart_ctrl_if bus();

  debug_hart_ctrl #(.RST_CYCLES(RST), .RCW(5)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: which phase the hart is in, as independent flags
  bit m_in_rst, m_sys, m_halting, m_halted, m_resuming, m_step, m_ack, m_prev_rr;
  bit m_dpc, m_cres;
  int unsigned m_quiet;
  logic [2:0] m_pend, m_cause;

  task automatic model_reset();
    m_in_rst = 1; m_sys = 1; m_quiet = 0; m_halting = 0; m_halted = 0;
    m_resuming = 0; m_step = 0; m_ack = 0; m_prev_rr = 0; m_dpc = 0;
    m_cres = 0; m_pend = 0; m_cause = 0;
  endtask

  task automatic model_step();
    bit rr_edge;
    rr_edge = bus.I_RESUMEREQ && !m_prev_rr;
    m_prev_rr = bus.I_RESUMEREQ;
    m_dpc = 0; m_cres = 0;
    if (bus.I_HARTRESET || bus.I_NDMRESET) begin
      m_in_rst = 1; m_quiet = 0; m_sys = m_sys | bus.I_NDMRESET; m_ack = 0;
      m_halting = 0; m_halted = 0; m_resuming = 0; m_step = 0;
    end else if (m_in_rst) begin
      if (m_quiet == RST) begin m_in_rst = 0; m_sys = 0; end
      else m_quiet++;
    end else if (m_halting) begin
      if (bus.I_CORE_IDLE) begin
        m_halting = 0; m_halted = 1; m_dpc = 1; m_cause = m_pend;
      end
    end else if (m_halted) begin
      if (rr_edge && !bus.I_HALTREQ) begin
        m_halted = 0; m_resuming = 1; m_cres = 1; m_ack = 0;
      end
    end else if (m_resuming) begin
      m_resuming = 0; m_ack = 1; m_step = bus.I_STEP;
    end else begin
      if (bus.I_CORE_EBREAK) begin m_pend = 1; m_halting = 1; m_step = 0; end
      else if (m_step && bus.I_CORE_RETIRE) begin m_pend = 4; m_halting = 1; m_step = 0; end
      else if (!m_step && bus.I_HALTREQ) begin m_pend = 3; m_halting = 1; end
    end
  endtask

  function automatic logic [11:0] model_out();
    bit stall;
    stall = m_in_rst | m_halting | m_halted | m_resuming;
    return {m_halted, !stall, m_ack, stall, m_halted | m_resuming, m_dpc,
            m_cause, m_cres, !m_in_rst, !(m_in_rst && m_sys)};
  endfunction

  function automatic logic [11:0] dut_out();
    return {bus.O_HALTED, bus.O_RUNNING, bus.O_RESUMEACK, bus.O_CORE_STALL,
            bus.O_DBG_MODE, bus.O_DPC_WE, bus.O_CAUSE, bus.O_CORE_RESUME,
            bus.O_CORE_RST_N, bus.O_SYS_RST_N};
  endfunction

  // {halted,running,ack,stall,dbg,dpc_we,cause[2:0],resume,core_rst_n,sys_rst_n}
  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else model_step();
    #1;
    chk("model_vs_dut", 32'(dut_out()), 32'(model_out()));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int n;
    model_reset();
    bus.I_HALTREQ = 0; bus.I_RESUMEREQ = 0; bus.I_HARTRESET = 0; bus.I_NDMRESET = 0;
    bus.I_STEP = 0; bus.I_CORE_IDLE = 0; bus.I_CORE_EBREAK = 0; bus.I_CORE_RETIRE = 0;
    cyc(3);
    chk("rst_core_rst_n", 32'(bus.O_CORE_RST_N), 0);
    chk("rst_sys_rst_n", 32'(bus.O_SYS_RST_N), 0);
    chk("rst_stall", 32'(bus.O_CORE_STALL), 1);
    chk("rst_running", 32'(bus.O_RUNNING), 0);

    // Counter starts at 16: 16 decrements, exit on the 17th edge
    rst_n = 1;
    cyc(16);
    chk("por_still_low", 32'(bus.O_CORE_RST_N), 0);
    cyc(1);
    chk("por_core_rst_n", 32'(bus.O_CORE_RST_N), 1);
    chk("por_sys_rst_n", 32'(bus.O_SYS_RST_N), 1);
    chk("por_running", 32'(bus.O_RUNNING), 1);

    // Halt request, core drains 5 cycles later
    bus.I_HALTREQ = 1;
    cyc(1);
    chk("halting_stall", 32'(bus.O_CORE_STALL), 1);
    chk("halting_running", 32'(bus.O_RUNNING), 0);
    cyc(4);
    bus.I_CORE_IDLE = 1;
    cyc(1);
    chk("halt_dpc_we", 32'(bus.O_DPC_WE), 1);
    chk("halt_cause", 32'(bus.O_CAUSE), 3);
    chk("halt_halted", 32'(bus.O_HALTED), 1);
    cyc(1);
    chk("halt_dpc_we_pulse", 32'(bus.O_DPC_WE), 0);
    bus.I_HALTREQ = 0;

    // Resume edge, then hold RESUMEREQ high
    bus.I_RESUMEREQ = 1;
    cyc(1);
    chk("resume_pulse", 32'(bus.O_CORE_RESUME), 1);
    chk("resume_ack_clr", 32'(bus.O_RESUMEACK), 0);
    cyc(1);
    chk("resume_running", 32'(bus.O_RUNNING), 1);
    chk("resume_ack", 32'(bus.O_RESUMEACK), 1);
    cyc(3);

    // Halt again with RESUMEREQ still high: no spurious resume
    bus.I_HALTREQ = 1;
    cyc(5);
    chk("rr_high_no_resume", 32'(bus.O_HALTED), 1);
    chk("ack_sticky_halted", 32'(bus.O_RESUMEACK), 1);
    bus.I_RESUMEREQ = 0;
    cyc(1);
    bus.I_RESUMEREQ = 1;
    cyc(2);
    bus.I_HALTREQ = 0;
    cyc(2);
    chk("edge_with_haltreq_dropped", 32'(bus.O_HALTED), 1);

    // Single step ending on retire
    bus.I_RESUMEREQ = 0; bus.I_STEP = 1;
    cyc(1);
    bus.I_RESUMEREQ = 1;
    cyc(2);
    chk("step_running", 32'(bus.O_RUNNING), 1);
    bus.I_HALTREQ = 1;
    cyc(2);
    chk("step_ignores_haltreq", 32'(bus.O_RUNNING), 1);
    bus.I_HALTREQ = 0; bus.I_CORE_RETIRE = 1;
    cyc(1);
    bus.I_CORE_RETIRE = 0;
    cyc(1);
    chk("step_cause", 32'(bus.O_CAUSE), 4);
    chk("step_ack_kept", 32'(bus.O_RESUMEACK), 1);

    // Ebreak and haltreq together
    bus.I_STEP = 0; bus.I_RESUMEREQ = 0;
    cyc(1);
    bus.I_RESUMEREQ = 1;
    cyc(2);
    bus.I_CORE_EBREAK = 1; bus.I_HALTREQ = 1;
    cyc(1);
    bus.I_CORE_EBREAK = 0;
    cyc(1);
    chk("ebreak_wins_cause", 32'(bus.O_CAUSE), 1);
    bus.I_HALTREQ = 0;

    // Hart reset while halting keeps the system out of reset
    bus.I_RESUMEREQ = 0;
    cyc(1);
    bus.I_RESUMEREQ = 1;
    cyc(2);
    bus.I_CORE_IDLE = 0; bus.I_HALTREQ = 1;
    cyc(1);
    bus.I_HALTREQ = 0; bus.I_HARTRESET = 1;
    cyc(1);
    bus.I_HARTRESET = 0;
    chk("hartreset_core", 32'(bus.O_CORE_RST_N), 0);
    chk("hartreset_sys", 32'(bus.O_SYS_RST_N), 1);
    chk("hartreset_ack", 32'(bus.O_RESUMEACK), 0);
    cyc(16);
    chk("hartreset_hold", 32'(bus.O_CORE_RST_N), 0);
    cyc(1);
    chk("hartreset_exit", 32'(bus.O_CORE_RST_N), 1);
    chk("hartreset_cause_kept", 32'(bus.O_CAUSE), 1);

    // ndmreset for 3 cycles while halted: 3+16 low cycles
    bus.I_CORE_IDLE = 1; bus.I_HALTREQ = 1;
    cyc(2);
    chk("pre_ndm_halted", 32'(bus.O_HALTED), 1);
    bus.I_HALTREQ = 0; bus.I_NDMRESET = 1;
    cyc(3);
    bus.I_NDMRESET = 0;
    chk("ndm_sys_low", 32'(bus.O_SYS_RST_N), 0);
    n = 3;
    for (int i = 0; i < 40 && bus.O_CORE_RST_N !== 1'b1; i++) begin
      cyc(1);
      if (bus.O_CORE_RST_N !== 1'b1) n++;
    end
    chk("ndm_low_cycles", 32'(n), 19);
    chk("ndm_sys_rel", 32'(bus.O_SYS_RST_N), 1);
    chk("ndm_running", 32'(bus.O_RUNNING), 1);
    chk("ndm_ack", 32'(bus.O_RESUMEACK), 0);
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
